// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_engine
//  Description : Iterative AES cipher core. It applies the initial
//                AddRoundKey and then NUM_ROUNDS rounds to one 128-bit
//                block, one round per clock, in encrypt or decrypt mode.
//                Round keys are read from an external asynchronous store
//                addressed by key_idx. The S-box is computed as a GF(2^8)
//                inverse plus an affine transform, with no lookup tables.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_round_engine #(
    parameter int NUM_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic         enc_en,
    output logic [3:0]   key_idx,
    input  logic [127:0] rkey,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);

    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS);

    generate
        if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_badRounds
            $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsmState_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gfMul(a, a);
        a3   = gfMul(a2, a);
        a6   = gfMul(a3, a3);
        a12  = gfMul(a6, a6);
        a15  = gfMul(a12, a3);
        a30  = gfMul(a15, a15);
        a60  = gfMul(a30, a30);
        a120 = gfMul(a60, a60);
        a240 = gfMul(a120, a120);
        a252 = gfMul(a240, a12);
        return gfMul(a252, a2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invAffine(input logic [7:0] a);
        return rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    endfunction

    // One inverter per byte serves both directions: the affine step is
    // applied after it for encrypt and its inverse before it for decrypt.
    function automatic logic [7:0] subByte(input logic [7:0] a, input logic enc);
        logic [7:0] x;
        logic [7:0] y;
        x = enc ? a : invAffine(a);
        y = gfInv(x);
        return enc ? affine(y) : y;
    endfunction

    function automatic logic [31:0] mixCol(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gfMul(a0, 8'h0E) ^ gfMul(a1, 8'h0B) ^ gfMul(a2, 8'h0D) ^ gfMul(a3, 8'h09),
                gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0E) ^ gfMul(a2, 8'h0B) ^ gfMul(a3, 8'h0D),
                gfMul(a0, 8'h0D) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0E) ^ gfMul(a3, 8'h0B),
                gfMul(a0, 8'h0B) ^ gfMul(a1, 8'h0D) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0E)};
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = mixCol(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = invMixCol(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fsmState_t    r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_cnt;
    logic         r_mode;
    logic [127:0] r_dout;
    logic         r_outValid;

    // ------------------------------------------------------------------
    // Round datapath. Byte k of the state lives in w_cur[15-k], so that
    // byte 0 is the most significant byte as in FIPS-197.
    // ------------------------------------------------------------------
    logic [15:0][7:0] w_cur;
    logic [15:0][7:0] w_sub;
    logic [15:0][7:0] w_shf;
    logic [127:0]     w_addKey;
    logic [127:0]     w_encOut;
    logic [127:0]     w_decOut;
    logic [127:0]     w_roundOut;
    logic             w_lastRound;

    assign w_cur       = r_state;
    assign w_lastRound = (r_cnt == C_LAST_ROUND);

    // Substitution and row shift commute, so substitute first, then
    // permute rows left (encrypt) or right (decrypt).
    always_comb begin
        w_sub = '0;
        w_shf = '0;
        for (int k = 0; k < 16; k++) begin
            w_sub[15 - k] = subByte(w_cur[15 - k], r_mode);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (r_mode) begin
                    w_shf[15 - (r + 4*c)] = w_sub[15 - (r + 4*((c + r) % 4))];
                end else begin
                    w_shf[15 - (r + 4*c)] = w_sub[15 - (r + 4*((c + 4 - r) % 4))];
                end
            end
        end
    end

    assign w_addKey   = w_shf ^ rkey;
    assign w_encOut   = w_lastRound ? w_addKey : (mixColumns(w_shf) ^ rkey);
    assign w_decOut   = w_lastRound ? w_addKey : invMixColumns(w_addKey);
    assign w_roundOut = r_mode ? w_encOut : w_decOut;

    // Round key index follows the FSM and the round counter directly so the
    // key store can answer within the same cycle.
    always_comb begin
        key_idx = 4'd0;
        case (r_fsm)
            IDLE:    key_idx = enc_en ? 4'd0 : C_LAST_ROUND;
            RUN:     key_idx = r_mode ? r_cnt : (C_LAST_ROUND - r_cnt);
            default: key_idx = 4'd0;
        endcase
    end

    // Control FSM, round state, counter and output hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= IDLE;
            r_state    <= '0;
            r_cnt      <= 4'd0;
            r_mode     <= 1'b1;
            r_dout     <= '0;
            r_outValid <= 1'b0;
        end else if (flush) begin
            r_fsm      <= IDLE;
            r_cnt      <= 4'd0;
            r_outValid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= din ^ rkey;
                        r_mode  <= enc_en;
                        r_cnt   <= 4'd1;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_roundOut;
                    if (w_lastRound) begin
                        r_dout     <= w_roundOut;
                        r_outValid <= 1'b1;
                        r_fsm      <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_fsm      <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign out_valid = r_outValid;
    assign dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_engine
//  Description : Directed bench for aes_round_engine with AES-128, -192 and
//                -256 instances, each fed by a key-schedule model of its own.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_round_engine;

    localparam logic [127:0] C_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C_CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         outReady;
    logic         encEn;
    logic [127:0] din;
    logic         inValid   [3];
    logic         inReady   [3];
    logic         outValid  [3];
    logic [3:0]   keyIdx    [3];
    logic [127:0] rkey      [3];
    logic [127:0] dout      [3];
    logic [127:0] roundKeys [3][16];
    logic [7:0]   sbox      [256];

    int nCmp = 0;
    int nErr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    assign rkey[0] = roundKeys[0][keyIdx[0]];
    assign rkey[1] = roundKeys[1][keyIdx[1]];
    assign rkey[2] = roundKeys[2][keyIdx[2]];

    aes_round_engine #(.NUM_ROUNDS(10)) u_dut10 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .din(din), .enc_en(encEn),
        .key_idx(keyIdx[0]), .rkey(rkey[0]),
        .out_valid(outValid[0]), .out_ready(outReady), .dout(dout[0])
    );

    aes_round_engine #(.NUM_ROUNDS(12)) u_dut12 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .din(din), .enc_en(encEn),
        .key_idx(keyIdx[1]), .rkey(rkey[1]),
        .out_valid(outValid[1]), .out_ready(outReady), .dout(dout[1])
    );

    aes_round_engine #(.NUM_ROUNDS(14)) u_dut14 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .din(din), .enc_en(encEn),
        .key_idx(keyIdx[2]), .rkey(rkey[2]),
        .out_valid(outValid[2]), .out_ready(outReady), .dout(dout[2])
    );

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward S-box generated by walking the multiplicative group with
    // generator 3 and its inverse in parallel.
    task automatic buildSbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Key expansion for the key 00 01 02 ... of nk words.
    task automatic expandKey(input int sel, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) roundKeys[sel][i] = '0;
        for (int i = 0; i < nk; i++) begin
            w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        end
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            roundKeys[sel][r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
        end
    endtask

    // Bounded wait for the engine to become ready again.
    task automatic waitReady(input int sel, input string tag);
        int n;
        n = 0;
        while (!inReady[sel] && n < 40) begin
            tick();
            n++;
        end
        checkVal({tag, "/ready_timeout"}, 128'(inReady[sel]), 128'(1));
    endtask

    // Accept one block, follow key_idx through every round and check the
    // result at the expected latency. Leaves the engine in DONE.
    task automatic runBlock(input int sel, input int nr, input logic [127:0] blk,
                            input logic enc, input logic [127:0] expOut,
                            input string tag, output int acceptCyc);
        din   = blk;
        encEn = enc;
        #1;
        checkVal({tag, "/in_ready"}, 128'(inReady[sel]), 128'(1));
        checkVal({tag, "/kidx_idle"}, 128'(keyIdx[sel]), enc ? 128'(0) : 128'(nr));
        inValid[sel] = 1'b1;
        acceptCyc    = cyc;
        tick();
        inValid[sel] = 1'b0;
        encEn        = ~enc;
        din          = ~blk;
        for (int c = 1; c <= nr; c++) begin
            checkVal({tag, "/kidx_run"}, 128'(keyIdx[sel]), enc ? 128'(c) : 128'(nr - c));
            checkVal({tag, "/ov_early"}, 128'(outValid[sel]), 128'(0));
            tick();
        end
        checkVal({tag, "/out_valid"}, 128'(outValid[sel]), 128'(1));
        checkVal({tag, "/dout"}, dout[sel], expOut);
        checkVal({tag, "/kidx_done"}, 128'(keyIdx[sel]), 128'(0));
        checkVal({tag, "/ready_done"}, 128'(inReady[sel]), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        logic sawOv;

        rst      = 1'b1;
        flush    = 1'b0;
        outReady = 1'b1;
        encEn    = 1'b1;
        din      = '0;
        for (int i = 0; i < 3; i++) inValid[i] = 1'b0;
        buildSbox();
        expandKey(0, 4);
        expandKey(1, 6);
        expandKey(2, 8);
        repeat (2) tick();

        // Reset state
        checkVal("rst/in_ready", 128'(inReady[2]), 128'(1));
        checkVal("rst/out_valid", 128'(outValid[2]), 128'(0));
        checkVal("rst/dout", dout[2], 128'(0));
        rst = 1'b0;
        tick();

        // AES-128 encrypt, FIPS-197 C.1
        runBlock(0, 10, C_PT, 1'b1, C_CT128, "aes128_enc", a1);
        tick();
        checkVal("aes128_enc/ov_drop", 128'(outValid[0]), 128'(0));
        checkVal("aes128_enc/ready_back", 128'(inReady[0]), 128'(1));

        // AES-256 decrypt, FIPS-197 C.3
        runBlock(2, 14, C_CT256, 1'b0, C_PT, "aes256_dec", a1);
        tick();

        // Backpressure on AES-256 encrypt
        outReady = 1'b0;
        runBlock(2, 14, C_PT, 1'b1, C_CT256, "bp", a1);
        inValid[2] = 1'b1;
        din        = 128'hdeadbeef_00000000_11111111_22222222;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVal("bp/dout_hold", dout[2], C_CT256);
            checkVal("bp/ready_low", 128'(inReady[2]), 128'(0));
            checkVal("bp/ov_hold", 128'(outValid[2]), 128'(1));
        end
        inValid[2] = 1'b0;
        outReady   = 1'b1;
        tick();
        checkVal("bp/ov_drop", 128'(outValid[2]), 128'(0));
        checkVal("bp/ready_back", 128'(inReady[2]), 128'(1));
        checkVal("bp/dout_kept", dout[2], C_CT256);

        // flush at T+4 of an AES-128 encrypt
        din        = C_PT;
        encEn      = 1'b1;
        inValid[0] = 1'b1;
        tick();
        inValid[0] = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkVal("flush/ready", 128'(inReady[0]), 128'(1));
        checkVal("flush/ov", 128'(outValid[0]), 128'(0));
        checkVal("flush/dout_kept", dout[0], C_CT128);
        sawOv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sawOv = sawOv | outValid[0];
        end
        checkVal("flush/no_output", 128'(sawOv), 128'(0));

        // flush together with in_valid in IDLE: nothing accepted
        flush      = 1'b1;
        inValid[0] = 1'b1;
        tick();
        flush      = 1'b0;
        inValid[0] = 1'b0;
        checkVal("flush_iv/not_accepted", 128'(inReady[0]), 128'(1));
        tick();
        checkVal("flush_iv/still_idle", 128'(inReady[0]), 128'(1));
        runBlock(0, 10, C_PT, 1'b1, C_CT128, "after_flush", a1);
        tick();

        // Asynchronous reset between edges at T+6
        din        = C_PT;
        encEn      = 1'b1;
        inValid[0] = 1'b1;
        tick();
        inValid[0] = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        checkVal("arst/ov", 128'(outValid[0]), 128'(0));
        checkVal("arst/dout", dout[0], 128'(0));
        checkVal("arst/ready", 128'(inReady[0]), 128'(1));
        #1;
        rst = 1'b0;
        tick();
        runBlock(0, 10, C_PT, 1'b1, C_CT128, "after_rst", a1);
        tick();

        // Back-to-back mixed modes on AES-192
        runBlock(1, 12, C_PT, 1'b1, C_CT192, "b2b_enc", a1);
        waitReady(1, "b2b");
        runBlock(1, 12, C_CT192, 1'b0, C_PT, "b2b_dec", a2);
        checkVal("b2b/spacing", 128'(a2 - a1), 128'(14));
        tick();
        checkVal("b2b/ready_back", 128'(inReady[1]), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative, parametrised AES core that applies the full cipher (initial AddRoundKey plus NUM_ROUNDS rounds) to one 128-bit block, one round per clock, in encrypt or decrypt mode. It generalises the single-round datapath into a complete round loop with a counter FSM, valid/ready handshakes and an output hold register. Round keys come from an external key-schedule store addressed by `key_idx`. It sits between the block-input FIFO and the output formatter of the AES-128/192/256 accelerator.

## Interface
- NUM_ROUNDS, default 14, total rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Any other value is an elaboration error.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort. Has priority over everything except rst.
- in_valid  in  1  `din` and `enc_en` are valid.
- in_ready  out  1  engine can accept a block.
- din  in  128  input block. Byte 0 = din[127:120]. Column-major state as in FIPS-197.
- enc_en  in  1  1 = encrypt, 0 = decrypt. Sampled with `din`.
- key_idx  out  4  index of the round key needed this cycle.
- rkey  in  128  round key `key_idx`. Supplied combinationally in the same cycle (async-read store).
- out_valid  out  1  `dout` holds a finished block.
- out_ready  in  1  downstream accepts `dout`.
- dout  out  128  result block. Registered.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Internal registers are `state[127:0]`, `cnt[3:0]` and `mode`.
- `in_ready` = (FSM == IDLE).
- **IDLE**
  - `key_idx` = enc_en ? 0 : NUM_ROUNDS.
  - On in_valid && in_ready: `state` <= din ^ rkey, `mode` <= enc_en, `cnt` <= 1, go to RUN.
- **RUN**
  - `key_idx` = mode ? cnt : NUM_ROUNDS − cnt.
  - Encrypt round: `state` <= MC(SR(SB(state))) ^ rkey. When cnt == NUM_ROUNDS, MixColumns is skipped.
  - Decrypt round: t = InvSB(InvSR(state)) ^ rkey, then `state` <= InvMC(t). When cnt == NUM_ROUNDS, InvMC is skipped and `state` <= t.
  - When cnt < NUM_ROUNDS: `cnt` <= cnt + 1.
  - When cnt == NUM_ROUNDS: `dout` <= round result, `out_valid` <= 1, go to DONE.
- **DONE**
  - `key_idx` = 0.
  - `dout` is held stable while out_valid && !out_ready.
  - On out_ready: `out_valid` <= 0, go to IDLE.
- **Datapath**
  - S-box and inverse S-box are computed as GF(2^8) inverse plus affine transform. There are no 256-entry tables.
  - MixColumns uses the xtime polynomial 0x11B.
  - All round logic is combinational between `state` and `rkey`.
- **flush**: FSM → IDLE, `out_valid` <= 0, `cnt` <= 0. Any in-flight or held block is discarded. `dout` keeps its old value.
- **Simultaneous events**
  - in_valid during RUN or DONE is ignored. Upstream holds it because in_ready is low.
  - flush together with in_valid in IDLE: flush wins and no block is accepted.
  - `enc_en` changing during RUN has no effect, because `mode` is latched at accept.

## Timing
- Reset values: FSM = IDLE, `out_valid` = 0, `dout` = 0, `cnt` = 0, `state` = 0, `mode` = 1. After reset, `in_ready` = 1.
- rst asserted mid-block aborts immediately. No output is produced for that block.
- Latency: accept at edge T gives out_valid = 1 after edge T + NUM_ROUNDS.
  - AES-128: 10 cycles.
  - AES-256: 14 cycles.
- Throughput with out_ready tied high: one block per NUM_ROUNDS + 2 cycles, since in_ready returns in the cycle after DONE.
- `key_idx` sequence in cycles T, T+1 … T+NUM_ROUNDS:
  - Encrypt: 0, 1, … NUM_ROUNDS.
  - Decrypt: NUM_ROUNDS, NUM_ROUNDS−1, … 0.
- `key_idx` is combinational from FSM and `cnt`. The key store must return `rkey` within the same cycle.
- `dout` is never X after reset and changes only on the final RUN edge.

## Test plan
- **AES-128 encrypt** (NUM_ROUNDS=10, key 000102…0f, bench key-schedule model driving `rkey` from `key_idx`): din 00112233445566778899aabbccddeeff, enc_en=1 → dout 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
- **AES-256 decrypt** (NUM_ROUNDS=14, key 000102…1f): din 8ea2b7ca516745bfeafc49904b496089, enc_en=0 → dout 00112233445566778899aabbccddeeff after 14 cycles. `key_idx` observed as 14 down to 0.
- **Backpressure**: hold out_ready=0 for 5 cycles after out_valid → dout stable, in_ready stays 0, and a second in_valid is not accepted. Raise out_ready → out_valid drops next edge and in_ready=1.
- **flush**:
  - Pulse flush at cycle T+4 of an AES-128 encrypt → no out_valid, FSM in IDLE next cycle.
  - Then encrypt the C.1 vector again → correct ciphertext.
- **Async reset mid-RUN**: assert rst between edges at cycle T+6 → out_valid, dout and cnt at 0 immediately. After release, the next block completes correctly.
- **Back-to-back mixed modes** (NUM_ROUNDS=12, key 000102…17): encrypt 00112233…eeff → dda97ca4864cdfe06eaf70a0ec0d7191. Feed that result back with enc_en=0 → original plaintext. Spacing between accepts is exactly 14 cycles with out_ready=1.
